// File: rtl/ddr_rd_checker.sv
// ddr_rd_checker: consumes the DDR AXI read channel, rebuilds the address-derived
// pattern for every returned beat, and tracks mismatches and protocol errors.
// Optional build macro: CHK_DATA_CAPTURE_EN adds first_err_data / first_err_exp.
module ddr_rd_checker #(
    parameter int          DATA_WIDTH     = 256,
    parameter int          ADDR_WIDTH     = 28,
    parameter int          LEN_WIDTH      = 8,
    parameter int          CMD_FIFO_DEPTH = 4,
    parameter int          ERR_CNT_WIDTH  = 16,
    parameter logic [31:0] PATTERN_SEED   = 32'h5A5A_0000
) (
    input  logic                     core_clk,
    input  logic                     core_rst,
    input  logic                     ddr_init_done,
    input  logic                     chk_clr,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDR_WIDTH-1:0]    cmd_addr,
    input  logic [LEN_WIDTH-1:0]     cmd_len,
    input  logic                     rd_valid,
    output logic                     rd_ready,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    input  logic                     rd_last,
    output logic                     busy,
    output logic                     err_flag,
    output logic                     proto_err,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic [ERR_CNT_WIDTH-1:0] beat_cnt,
    output logic [ADDR_WIDTH-1:0]    first_err_addr
`ifdef CHK_DATA_CAPTURE_EN
    ,
    output logic [DATA_WIDTH-1:0]    first_err_data,
    output logic [DATA_WIDTH-1:0]    first_err_exp
`endif
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int NUM_WORDS  = DATA_WIDTH / 32;
    localparam int PTR_W      = $clog2(CMD_FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state;

    // Outstanding burst queue
    logic [ADDR_WIDTH-1:0] fifo_addr [CMD_FIFO_DEPTH];
    logic [LEN_WIDTH-1:0]  fifo_len  [CMD_FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [LEN_WIDTH-1:0]  beat_idx;

    logic                  run, full, empty, leave, flush;
    logic                  push, take, pop, len_err, orphan;
    logic [ADDR_WIDTH-1:0] head_addr, beat_addr;
    logic [LEN_WIDTH-1:0]  head_len;
    logic [DATA_WIDTH-1:0] exp_data;

    // Compare pipeline stage 1
    logic                  s1_vld;
    logic [DATA_WIDTH-1:0] s1_data, s1_exp;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic                  s2_upd, mis_hit, first_hit;

    assign run       = (state == RUN);
    assign full      = (count == CNT_W'(CMD_FIFO_DEPTH));
    assign empty     = (count == '0);
    assign leave     = run && !ddr_init_done;
    assign flush     = chk_clr || leave;
    assign cmd_ready = run && !full && !chk_clr;
    assign rd_ready  = run && !chk_clr;
    assign busy      = !empty || s1_vld;

    // A beat accepted in the cycle the checker leaves RUN is dropped with the flush
    assign push   = cmd_valid && cmd_ready && ddr_init_done;
    assign take   = rd_valid && rd_ready && ddr_init_done;
    assign orphan = take && empty;
    assign pop    = take && !empty && rd_last;

    assign head_addr = fifo_addr[rd_ptr];
    assign head_len  = fifo_len[rd_ptr];
    assign beat_addr = head_addr + ADDR_WIDTH'(beat_idx) * ADDR_WIDTH'(BEAT_BYTES);

    // Early last, or a beat past the declared length, is a protocol error
    assign len_err = take && !empty &&
                     (rd_last ? (beat_idx < head_len) : (beat_idx == head_len));

    // Expected word k is the byte address of that word XORed with the seed
    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
        logic [ADDR_WIDTH-1:0] word_addr;
        assign word_addr = beat_addr + ADDR_WIDTH'(4 * k);
        assign exp_data[32*k +: 32] = 32'(word_addr) ^ PATTERN_SEED;
    end

    // Stage 2 result is dropped on clear or when leaving RUN
    assign s2_upd    = s1_vld && !leave && !chk_clr;
    assign mis_hit   = s2_upd && (s1_data != s1_exp);
    assign first_hit = mis_hit && !err_flag;

    // Run/idle state follows DDR calibration
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (ddr_init_done)  state <= RUN;
                RUN:     if (!ddr_init_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Queue storage; contents are don't-care while count says empty
    always_ff @(posedge core_clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cmd_addr;
            fifo_len[wr_ptr]  <= cmd_len;
        end
    end

    // Queue pointers, occupancy and the beat index inside the head burst
    always_ff @(posedge core_clk) begin
        if (core_rst || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_idx <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (take && !empty) begin
                if (rd_last)
                    beat_idx <= '0;
                else if (beat_idx != head_len)
                    beat_idx <= beat_idx + LEN_WIDTH'(1);
            end
        end
    end

    // Stage 1 valid: only beats with a matching command enter the pipe
    always_ff @(posedge core_clk) begin
        if (core_rst || flush) s1_vld <= 1'b0;
        else                   s1_vld <= take && !empty;
    end

    // Stage 1 payload: read data, regenerated pattern and beat address
    always_ff @(posedge core_clk) begin
        if (take && !empty) begin
            s1_data <= rd_data;
            s1_exp  <= exp_data;
            s1_addr <= beat_addr;
        end
    end

    // Stage 2: compare result into sticky flags and counters; clear wins
    always_ff @(posedge core_clk) begin
        if (core_rst || chk_clr) begin
            err_flag       <= 1'b0;
            proto_err      <= 1'b0;
            err_cnt        <= '0;
            beat_cnt       <= '0;
            first_err_addr <= '0;
        end else begin
            if (orphan || len_err) proto_err <= 1'b1;
            if (s2_upd) beat_cnt <= beat_cnt + ERR_CNT_WIDTH'(1);
            if (mis_hit) begin
                err_flag <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
            end
            if (first_hit) first_err_addr <= s1_addr;
        end
    end

`ifdef CHK_DATA_CAPTURE_EN
    // Snapshot of the first failing beat for debug readout
    always_ff @(posedge core_clk) begin
        if (core_rst || chk_clr) begin
            first_err_data <= '0;
            first_err_exp  <= '0;
        end else if (first_hit) begin
            first_err_data <= s1_data;
            first_err_exp  <= s1_exp;
        end
    end
`endif

endmodule

// File: tb/tb_ddr_rd_checker.sv
// Testbench for ddr_rd_checker: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_ddr_rd_checker;

    localparam int DEPTH = 4;
    localparam logic [31:0] SEED = 32'h5A5A_0000;

    logic         clk = 1'b0;
    logic         rst, init, clr, cv, rv, rl;
    logic [27:0]  caddr;
    logic [7:0]   clen;
    logic [255:0] rd;
    logic         cmd_ready, rd_ready, busy, err_flag, proto_err;
    logic [15:0]  err_cnt, beat_cnt;
    logic [27:0]  first_err_addr;
`ifdef CHK_DATA_CAPTURE_EN
    logic [255:0] first_err_data, first_err_exp;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ddr_rd_checker dut (
        .core_clk(clk), .core_rst(rst), .ddr_init_done(init), .chk_clr(clr),
        .cmd_valid(cv), .cmd_ready(cmd_ready), .cmd_addr(caddr), .cmd_len(clen),
        .rd_valid(rv), .rd_ready(rd_ready), .rd_data(rd), .rd_last(rl),
        .busy(busy), .err_flag(err_flag), .proto_err(proto_err),
        .err_cnt(err_cnt), .beat_cnt(beat_cnt), .first_err_addr(first_err_addr)
`ifdef CHK_DATA_CAPTURE_EN
        , .first_err_data(first_err_data), .first_err_exp(first_err_exp)
`endif
    );

    // Expected beat pattern straight from the address rule
    function automatic logic [255:0] pat(input logic [27:0] a);
        logic [255:0] r;
        logic [27:0]  w;
        for (int k = 0; k < 8; k++) begin
            w = a + 28'(4 * k);
            r[32*k +: 32] = {4'b0, w} ^ SEED;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Advance to the next cycle with idle inputs; init is persistent
    task automatic nxt();
        @(posedge clk);
        #1;
        cv = 0; rv = 0; rl = 0; clr = 0; rd = '0; caddr = '0; clen = '0;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_rdy(input string nm);
        bit ok = 0;
        for (int k = 0; k < 10; k++) begin
            nxt(); smp();
            if (cmd_ready) begin ok = 1; break; end
        end
        chk(nm, 64'(ok), 64'd1);
    endtask

    task automatic do_clr(input string nm);
        nxt(); clr = 1; smp();
        chk({nm, "_rd_ready"}, 64'(rd_ready), 64'd0);
        chk({nm, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
        nxt(); smp();
        chk({nm, "_flags"}, {62'd0, err_flag, proto_err}, 64'd0);
        chk({nm, "_cnts"}, {32'd0, err_cnt, beat_cnt}, 64'd0);
        chk({nm, "_faddr"}, 64'(first_err_addr), 64'd0);
    endtask

    // Vector table record: inputs for one cycle and outputs seen in that cycle
    typedef struct {
        bit          cv;
        logic [27:0] caddr;
        logic [7:0]  clen;
        bit          rv, rl;
        logic [27:0] daddr;
        bit          bad_bit;
        bit          e_crdy, e_busy, e_eflag;
        int          e_ecnt, e_bcnt;
        logic [27:0] e_faddr;
    } vec_t;

    function automatic vec_t mk(bit c, logic [27:0] ca, logic [7:0] cl, bit r, bit l,
                                logic [27:0] da, bit bb, bit ecr, bit ebu, bit eef,
                                int eec, int ebc, logic [27:0] efa);
        vec_t v;
        v.cv = c; v.caddr = ca; v.clen = cl; v.rv = r; v.rl = l; v.daddr = da;
        v.bad_bit = bb; v.e_crdy = ecr; v.e_busy = ebu; v.e_eflag = eef;
        v.e_ecnt = eec; v.e_bcnt = ebc; v.e_faddr = efa;
        return v;
    endfunction

    // Reference model state
    typedef struct { logic [27:0] addr; int len; } mcmd_t;
    typedef struct { int due; logic [27:0] addr; bit mis; } mev_t;
    mcmd_t       mq[$];
    mev_t        mev[$];
    bit          m_run, m_ef, m_pf;
    int          m_idx, m_ec, m_bc, m_step;
    logic [27:0] m_fa;

    // One clock edge of the model, using the inputs driven this cycle
    task automatic model_step();
        bit          cr, rr;
        logic [27:0] a;
        mev_t        e;
        cr = m_run && mq.size() < DEPTH && !clr;
        rr = m_run && !clr;
        m_step++;
        if (clr) begin
            m_ef = 0; m_pf = 0; m_ec = 0; m_bc = 0; m_fa = '0; m_idx = 0;
            mq.delete(); mev.delete();
        end else if (m_run && !init) begin
            mq.delete(); mev.delete(); m_idx = 0;
        end else begin
            while (mev.size() > 0 && mev[0].due == m_step) begin
                e = mev.pop_front();
                m_bc = (m_bc + 1) % 65536;
                if (e.mis) begin
                    if (!m_ef) m_fa = e.addr;
                    m_ef = 1;
                    if (m_ec < 65535) m_ec++;
                end
            end
            if (rv && rr) begin
                if (mq.size() == 0) m_pf = 1;
                else begin
                    a = mq[0].addr + 28'(m_idx * 32);
                    e.due = m_step + 1; e.addr = a; e.mis = (rd !== pat(a));
                    mev.push_back(e);
                    if (rl) begin
                        if (m_idx < mq[0].len) m_pf = 1;
                        void'(mq.pop_front());
                        m_idx = 0;
                    end else if (m_idx == mq[0].len) m_pf = 1;
                    else m_idx++;
                end
            end
            if (cv && cr) begin
                mcmd_t c;
                c.addr = caddr; c.len = int'(clen);
                mq.push_back(c);
            end
        end
        if (m_run && !init) m_run = 0;
        else if (!m_run && init) m_run = 1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[17];
        rst = 1; init = 1; clr = 0; cv = 0; rv = 0; rl = 0; rd = '0; caddr = '0; clen = '0;

        // Reset state
        nxt(); nxt(); smp();
        chk("rst_ready", {62'd0, cmd_ready, rd_ready}, 64'd0);
        chk("rst_flags", {61'd0, busy, err_flag, proto_err}, 64'd0);
        chk("rst_cnts", {32'd0, err_cnt, beat_cnt}, 64'd0);
        chk("rst_faddr", 64'(first_err_addr), 64'd0);
        nxt(); rst = 0;
        wait_rdy("run_after_rst");

        // Good burst at 0x100, then same burst with beat 2 corrupted, then a later error
        tbl[0]  = mk(1, 28'h100, 3, 0, 0, 0,      0, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0,       1, 0, 28'h100, 0, 1, 1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0,       1, 0, 28'h120, 0, 1, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0,       1, 0, 28'h140, 0, 1, 1, 0, 0, 1, 0);
        tbl[4]  = mk(0, 0, 0,       1, 1, 28'h160, 0, 1, 1, 0, 0, 2, 0);
        tbl[5]  = mk(0, 0, 0,       0, 0, 0,      0, 1, 1, 0, 0, 3, 0);
        tbl[6]  = mk(0, 0, 0,       0, 0, 0,      0, 1, 0, 0, 0, 4, 0);
        tbl[7]  = mk(1, 28'h100, 3, 0, 0, 0,      0, 1, 0, 0, 0, 4, 0);
        tbl[8]  = mk(0, 0, 0,       1, 0, 28'h100, 0, 1, 1, 0, 0, 4, 0);
        tbl[9]  = mk(0, 0, 0,       1, 0, 28'h120, 0, 1, 1, 0, 0, 4, 0);
        tbl[10] = mk(0, 0, 0,       1, 0, 28'h140, 1, 1, 1, 0, 0, 5, 0);
        tbl[11] = mk(0, 0, 0,       1, 1, 28'h160, 0, 1, 1, 0, 0, 6, 0);
        tbl[12] = mk(0, 0, 0,       0, 0, 0,      0, 1, 1, 1, 1, 7, 28'h140);
        tbl[13] = mk(1, 28'h160, 0, 0, 0, 0,      0, 1, 0, 1, 1, 8, 28'h140);
        tbl[14] = mk(0, 0, 0,       1, 1, 28'h160, 1, 1, 1, 1, 1, 8, 28'h140);
        tbl[15] = mk(0, 0, 0,       0, 0, 0,      0, 1, 1, 1, 1, 8, 28'h140);
        tbl[16] = mk(0, 0, 0,       0, 0, 0,      0, 1, 0, 1, 2, 9, 28'h140);
        for (int i = 0; i < 17; i++) begin
            nxt();
            cv = tbl[i].cv; caddr = tbl[i].caddr; clen = tbl[i].clen;
            rv = tbl[i].rv; rl = tbl[i].rl;
            rd = pat(tbl[i].daddr) ^ (tbl[i].bad_bit ? 256'd1 : 256'd0);
            smp();
            chk($sformatf("tbl%0d_cmd_ready", i), 64'(cmd_ready), 64'(tbl[i].e_crdy));
            chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_err_flag", i), 64'(err_flag), 64'(tbl[i].e_eflag));
            chk($sformatf("tbl%0d_err_cnt", i), 64'(err_cnt), 64'(tbl[i].e_ecnt));
            chk($sformatf("tbl%0d_beat_cnt", i), 64'(beat_cnt), 64'(tbl[i].e_bcnt));
            chk($sformatf("tbl%0d_faddr", i), 64'(first_err_addr), 64'(tbl[i].e_faddr));
        end
`ifdef CHK_DATA_CAPTURE_EN
        chk("cap_exp_w0", 64'(first_err_exp[31:0]), 64'h5A5A0140);
        chk("cap_data_w0", 64'(first_err_data[31:0]), 64'h5A5A0141);
`endif

        // FIFO full: four queued bursts block the fifth until a pop
        do_clr("clr_a");
        for (int j = 1; j <= 4; j++) begin
            nxt(); cv = 1; caddr = 28'(j * 'h1000); clen = 0; smp();
            chk($sformatf("fill%0d_ready", j), 64'(cmd_ready), 64'd1);
        end
        nxt(); cv = 1; caddr = 28'h5000; smp();
        chk("full_ready", 64'(cmd_ready), 64'd0);
        nxt(); cv = 1; caddr = 28'h5000; rv = 1; rl = 1; rd = pat(28'h1000); smp();
        chk("full_pop_ready", 64'(cmd_ready), 64'd0);
        nxt(); smp();
        chk("after_pop_ready", 64'(cmd_ready), 64'd1);
        for (int j = 2; j <= 4; j++) begin
            nxt(); rv = 1; rl = 1; rd = pat(28'(j * 'h1000)); smp();
        end
        nxt(); smp(); nxt(); smp();
        chk("drain_beat_cnt", 64'(beat_cnt), 64'd4);
        chk("drain_flags", {61'd0, busy, err_flag, proto_err}, 64'd0);

        // Orphan beat: protocol error, not counted
        nxt(); rv = 1; rl = 1; rd = '0; smp();
        nxt(); smp(); nxt(); smp();
        chk("orphan_proto", 64'(proto_err), 64'd1);
        chk("orphan_cnts", {32'd0, err_cnt, beat_cnt}, {32'd0, 16'd0, 16'd4});
        chk("orphan_busy", 64'(busy), 64'd0);

        // Early rd_last on a two-beat burst pops the head
        do_clr("clr_b");
        nxt(); cv = 1; caddr = 28'h200; clen = 1;
        nxt(); rv = 1; rl = 1; rd = pat(28'h200); smp();
        nxt(); smp();
        chk("early_last_proto", 64'(proto_err), 64'd1);
        nxt(); smp();
        chk("early_last_busy", 64'(busy), 64'd0);
        chk("early_last_cnts", {32'd0, err_cnt, beat_cnt}, {32'd0, 16'd0, 16'd1});

        // Saturation: 0xFFFF+2 bad beats repeating the single-beat burst address
        do_clr("clr_c");
        nxt(); cv = 1; caddr = 28'h0; clen = 0;
        for (int n = 0; n < 65537; n++) begin
            nxt(); rv = 1; rd = '0;
        end
        nxt(); smp(); nxt(); smp();
        chk("sat_err_cnt", 64'(err_cnt), 64'hFFFF);
        chk("sat_beat_cnt_wrap", 64'(beat_cnt), 64'd1);
        chk("sat_flags", {62'd0, err_flag, proto_err}, 64'd3);

        // Clear coincident with a bad beat, with another bad beat already in flight
        nxt(); rv = 1; rd = '0;
        nxt(); rv = 1; rd = '0; clr = 1; smp();
        chk("clr_bad_rd_ready", 64'(rd_ready), 64'd0);
        nxt(); smp();
        chk("clr_bad_flags", {61'd0, busy, err_flag, proto_err}, 64'd0);
        chk("clr_bad_cnts", {32'd0, err_cnt, beat_cnt}, 64'd0);
        nxt(); smp();
        chk("clr_bad_cnts2", {32'd0, err_cnt, beat_cnt}, 64'd0);

        // Calibration loss mid-burst flushes the queue, holds the counters
        nxt(); cv = 1; caddr = 28'h300; clen = 3;
        nxt(); rv = 1; rd = pat(28'h300);
        nxt(); rv = 1; rd = pat(28'h320) ^ 256'd1;
        nxt(); nxt(); smp();
        chk("drop_pre_err_cnt", 64'(err_cnt), 64'd1);
        nxt(); init = 0; smp();
        chk("drop_cycle_rd_ready", 64'(rd_ready), 64'd1);
        nxt(); smp();
        chk("drop_ready", {62'd0, cmd_ready, rd_ready}, 64'd0);
        chk("drop_busy", 64'(busy), 64'd0);
        chk("drop_err_held", {32'd0, err_cnt, beat_cnt}, {32'd0, 16'd1, 16'd2});
        chk("drop_faddr", 64'(first_err_addr), 64'h320);
        nxt(); init = 1;
        wait_rdy("rerun_ready");
        nxt(); rv = 1; rl = 1; rd = pat(28'h340);
        nxt(); smp(); nxt(); smp();
        chk("rerun_orphan_proto", 64'(proto_err), 64'd1);
        chk("rerun_cnts", {32'd0, err_cnt, beat_cnt}, {32'd0, 16'd1, 16'd2});

        // Randomized traffic against the reference model
        do_clr("clr_rnd");
        m_run = 1; m_ef = 0; m_pf = 0; m_idx = 0; m_ec = 0; m_bc = 0; m_fa = '0; m_step = 0;
        mq.delete(); mev.delete();
        for (int n = 0; n < 4000; n++) begin
            logic [27:0] a;
            int          b;
            nxt();
            if (init) begin
                if ($urandom_range(299) == 0) init = 0;
            end else if ($urandom_range(2) == 0) init = 1;
            clr = ($urandom_range(199) == 0);
            if ($urandom_range(9) < 4) begin
                cv = 1;
                clen = 8'($urandom_range(3));
                caddr = ($urandom_range(7) == 0) ? 28'hFFFFFC0 : (28'($urandom) & 28'hFFFFFE0);
            end
            if ($urandom_range(9) < 6) begin
                rv = 1;
                if (mq.size() > 0) begin
                    a = mq[0].addr + 28'(m_idx * 32);
                    rd = pat(a);
                    if ($urandom_range(4) == 0) begin
                        b = $urandom_range(255);
                        rd[b] = ~rd[b];
                    end
                    rl = (m_idx == mq[0].len);
                    if ($urandom_range(19) == 0) rl = !rl;
                end else begin
                    rd = {8{$urandom}};
                    rl = 1'($urandom_range(1));
                end
            end
            smp();
            chk("rnd_cmd_ready", 64'(cmd_ready), 64'(m_run && mq.size() < DEPTH && !clr));
            chk("rnd_rd_ready", 64'(rd_ready), 64'(m_run && !clr));
            chk("rnd_busy", 64'(busy), 64'(mq.size() != 0 || mev.size() != 0));
            chk("rnd_err_flag", 64'(err_flag), 64'(m_ef));
            chk("rnd_proto_err", 64'(proto_err), 64'(m_pf));
            chk("rnd_err_cnt", 64'(err_cnt), 64'(m_ec));
            chk("rnd_beat_cnt", 64'(beat_cnt), 64'(m_bc));
            chk("rnd_faddr", 64'(first_err_addr), 64'(m_fa));
            model_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr_rd_checker.md
Name: ddr_rd_checker

Overview:
- Downstream consumer of the DDR3/LPDDR AXI read channel in the board-level DDR test design. It sits between the AXI read interface of the DDR IP and the err_flag_led / UART status logic.
- Queues issued read-burst commands, regenerates the address-derived expected pattern for every returned beat, and compares it against the read data.
- Reports error flags, counters, and the address of the first failing beat.

Parameters:
- DATA_WIDTH, 256, read-data width in bits (MEM_DQ_WIDTH*8); multiple of 32.
- ADDR_WIDTH, 28, byte-address width.
- LEN_WIDTH, 8, burst-length field width (AXI len: beats-1).
- CMD_FIFO_DEPTH, 4, outstanding-burst queue depth; power of 2, >=2.
- ERR_CNT_WIDTH, 16, width of the error and beat counters.
- PATTERN_SEED, 32'h5A5A_0000, XOR seed applied to every expected word.

Ports:
- core_clk, in, 1, the only clock.
- core_rst, in, 1, synchronous active-high reset.
- ddr_init_done, in, 1, DDR calibration complete; the checker runs only while this is high.
- chk_clr, in, 1, single-cycle pulse that clears flags, counters and the cmd FIFO.
- cmd_valid, in, 1, read burst issued upstream.
- cmd_ready, out, 1, cmd FIFO not full and state is RUN.
- cmd_addr, in, ADDR_WIDTH, burst start byte address; aligned to DATA_WIDTH/8.
- cmd_len, in, LEN_WIDTH, beats-1.
- rd_valid, in, 1, read beat valid.
- rd_ready, out, 1, beat accepted.
- rd_data, in, DATA_WIDTH, read beat data.
- rd_last, in, 1, last beat of the burst.
- busy, out, 1, cmd FIFO non-empty or compare pipeline occupied.
- err_flag, out, 1, sticky data-mismatch flag.
- proto_err, out, 1, sticky length/orphan-beat error flag.
- err_cnt, out, ERR_CNT_WIDTH, count of mismatching beats; saturating.
- beat_cnt, out, ERR_CNT_WIDTH, count of checked beats; wraps.
- first_err_addr, out, ADDR_WIDTH, byte address of the first mismatching beat.

Behaviour:
- Reset (core_rst=1 at a core_clk edge): all outputs 0. cmd FIFO is emptied, pipeline is flushed, state is IDLE.
- States:
  - IDLE -> RUN when ddr_init_done=1.
  - RUN -> IDLE when ddr_init_done=0. Leaving RUN flushes the FIFO and pipeline; flags and counters are held.
- chk_clr in any state, on the next edge:
  - zeroes err_flag, proto_err, err_cnt, beat_cnt, first_err_addr;
  - empties the cmd FIFO and flushes the pipeline;
  - discards any beat or cmd accepted in that same cycle;
  - takes priority over a simultaneous error update.
- cmd handshake:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = RUN && !full && !chk_clr.
  - Full means CMD_FIFO_DEPTH entries. A push and pop in the same cycle while full is refused (ready computed from the registered count).
- rd handshake:
  - rd_ready = RUN && !chk_clr. No other backpressure.
  - An accepted beat uses the FIFO head and a beat index i (0..cmd_len).
- Beat address: A = head.addr + i*(DATA_WIDTH/8), truncated to ADDR_WIDTH.
- Expected 32-bit word k (k = 0..DATA_WIDTH/32-1) = zero-extend(A + 4*k, 32) XOR PATTERN_SEED. Word k occupies bits [32k+31:32k].
- Pipeline:
  - Stage 1 registers data, expected value and A.
  - Stage 2 registers the compare result and updates the counters.
  - err_flag, err_cnt and beat_cnt change 2 cycles after the beat handshake.
  - Full throughput: one beat per cycle.
- first_err_addr latches A only while err_flag=0, i.e. on the first mismatch after reset/clr.
- err_cnt saturates at all-ones; beat_cnt wraps to 0.
- Pop and index rules:
  - The FIFO head pops on an accepted beat with rd_last=1; i resets to 0.
  - If i==cmd_len and rd_last=0: set proto_err, keep the head, and hold i at cmd_len; the pattern repeats the last address until rd_last arrives.
  - If rd_last=1 and i<cmd_len: set proto_err and pop.
- Orphan beat (FIFO empty at an accepted beat): set proto_err, discard the beat, leave err_cnt and beat_cnt unchanged.
- A push into an empty FIFO in cycle N becomes the head for a beat in cycle N+1. A beat in cycle N itself is an orphan.
- busy = FIFO count != 0 || either stage valid.

Optional Feature:
- Macro: CHK_DATA_CAPTURE_EN.
- Defined: adds outputs first_err_data (DATA_WIDTH) and first_err_exp (DATA_WIDTH). Both latch alongside first_err_addr, reset and clear to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset release with ddr_init_done=1: one cmd (addr 0x100, len 3), then 4 correct beats, last on beat 3 -> beat_cnt=4, err_cnt=0, err_flag=0, busy=0 two cycles after the last beat.
- Same burst with beat 2, word 0 XOR 1 -> err_flag=1 exactly 2 cycles after beat 2; err_cnt=1; first_err_addr=0x140; a later error at 0x160 leaves first_err_addr=0x140.
- Push 4 cmds without beats -> cmd_ready=0 while holding 4 entries; 5th cmd not accepted; after one rd_last beat, cmd_ready=1 on the next cycle.
- Beat with empty FIFO -> proto_err=1, beat_cnt unchanged. len=1 burst with rd_last on beat 0 -> proto_err=1, FIFO pops.
- 0xFFFF+2 mismatching beats -> err_cnt=0xFFFF (saturated). chk_clr pulse coincident with a bad beat -> all flags/counters 0 and the bad beat is not counted.
- ddr_init_done drops mid-burst -> cmd_ready=rd_ready=0 next cycle, FIFO empty, err_cnt held. With CHK_DATA_CAPTURE_EN: first_err_exp word 0 = 0x5A5A0140 in scenario 2.
